// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcodes and fetch state encoding
package cpu_pkg;

  localparam int ADDR_W  = 8;
  localparam int INSTR_W = 16;

  localparam logic [7:0]         JUMPR_OPC = 8'h9A;
  localparam logic [INSTR_W-1:0] NOP       = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/jumpr_predecode.sv
// rtl/jumpr_predecode.sv - recognises JUMPR and computes its PC-relative target
module jumpr_predecode
  import cpu_pkg::*;
#(
  parameter logic [7:0] OPC = JUMPR_OPC
) (
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [ADDR_W-1:0]  i_pc,
  output logic               o_is_jumpr,
  output logic [ADDR_W-1:0]  o_target,
  output logic               o_is_self
);

  logic signed [7:0] w_offset;

  assign w_offset   = $signed(i_instr[7:0]);
  assign o_is_jumpr = (i_instr[15:8] == OPC);
  // Offset is relative to the following instruction; the sum wraps with the PC width.
  assign o_target   = i_pc + ADDR_W'(1) + ADDR_W'(w_offset);
  assign o_is_self  = o_is_jumpr && (o_target == i_pc);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC/IR registers and IDLE/RUN/HALT fetch control
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [7:0]        OPC_JUMPR = JUMPR_OPC
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_run_en,
  input  logic               i_stall,
  input  logic               i_redirect_en,
  input  logic [ADDR_W-1:0]  i_redirect_addr,
  input  logic [INSTR_W-1:0] i_instr_in,
  output logic [ADDR_W-1:0]  o_pc_out,
  output logic [INSTR_W-1:0] o_ir_out,
  output logic [ADDR_W-1:0]  o_ir_pc,
  output logic               o_ir_valid,
  output logic               o_halted
);

  fetch_state_t r_state, w_state_nxt;

  logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
  logic [INSTR_W-1:0] r_ir, w_ir_nxt;
  logic [ADDR_W-1:0]  r_ir_pc, w_ir_pc_nxt;
  logic               r_ir_valid, w_ir_valid_nxt;

  logic               w_is_jumpr;
  logic [ADDR_W-1:0]  w_target;
  logic               w_is_self;

  jumpr_predecode #(.OPC(OPC_JUMPR)) u_predecode (
    .i_instr    (i_instr_in),
    .i_pc       (r_pc),
    .o_is_jumpr (w_is_jumpr),
    .o_target   (w_target),
    .o_is_self  (w_is_self)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= NOP;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_ir       <= w_ir_nxt;
      r_ir_pc    <= w_ir_pc_nxt;
      r_ir_valid <= w_ir_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_ir_nxt       = r_ir;
    w_ir_pc_nxt    = r_ir_pc;
    w_ir_valid_nxt = r_ir_valid;
    case (r_state)
      ST_IDLE: begin
        w_ir_valid_nxt = 1'b0;
        if (i_redirect_en) w_pc_nxt = i_redirect_addr;
        if (i_run_en) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (i_redirect_en) begin
          w_pc_nxt       = i_redirect_addr;
          w_ir_valid_nxt = 1'b0;
        end else if (i_stall) begin
          w_pc_nxt = r_pc;
        end else if (w_is_jumpr) begin
          // Folded jump: the decoder sees a bubble instead of the JUMPR word.
          w_pc_nxt       = w_target;
          w_ir_valid_nxt = 1'b0;
          if (w_is_self) w_state_nxt = ST_HALT;
        end else begin
          w_ir_nxt       = i_instr_in;
          w_ir_pc_nxt    = r_pc;
          w_ir_valid_nxt = 1'b1;
          w_pc_nxt       = r_pc + ADDR_W'(1);
        end
      end
      ST_HALT: begin
        w_ir_valid_nxt = 1'b0;
        if (i_redirect_en) begin
          w_pc_nxt    = i_redirect_addr;
          w_state_nxt = ST_RUN;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_ir_valid_nxt = 1'b0;
      end
    endcase
  end

  assign o_pc_out   = r_pc;
  assign o_ir_out   = r_ir;
  assign o_ir_pc    = r_ir_pc;
  assign o_ir_valid = r_ir_valid;
  assign o_halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_run_en = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_redirect_en = 1'b0;
  logic [7:0]  i_redirect_addr = 8'h00;
  logic [15:0] i_instr_in;
  logic [7:0]  o_pc_out;
  logic [15:0] o_ir_out;
  logic [7:0]  o_ir_pc;
  logic        o_ir_valid;
  logic        o_halted;

  logic [15:0] rom [256];
  int checks = 0;
  int errors = 0;

  // Reference machine state: started = left IDLE, halted = parked on jump-to-self.
  bit          m_started, m_halted, m_valid;
  int          m_pc, m_ir_pc;
  logic [15:0] m_ir;

  always #5 i_clk = ~i_clk;
  assign i_instr_in = rom[o_pc_out];

  fetch_unit dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_run_en(i_run_en), .i_stall(i_stall),
    .i_redirect_en(i_redirect_en), .i_redirect_addr(i_redirect_addr),
    .i_instr_in(i_instr_in), .o_pc_out(o_pc_out), .o_ir_out(o_ir_out),
    .o_ir_pc(o_ir_pc), .o_ir_valid(o_ir_valid), .o_halted(o_halted)
  );

  typedef struct {
    logic rst, run, stall, redir;
    logic [7:0] raddr;
    logic [7:0] pc;
    logic [15:0] ir;
    logic [7:0] irpc;
    logic v, h;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit run, input bit st, input bit rd,
                            input int ra);
    logic [15:0] w;
    int off, tgt;
    w = rom[m_pc];
    if (rst) begin
      m_started = 0; m_halted = 0; m_valid = 0; m_pc = 0; m_ir_pc = 0; m_ir = 16'h0000;
    end else if (!m_started) begin
      m_valid = 0;
      if (rd) m_pc = ra;
      if (run) m_started = 1;
    end else if (m_halted) begin
      m_valid = 0;
      if (rd) begin m_pc = ra; m_halted = 0; end
    end else if (rd) begin
      m_pc = ra; m_valid = 0;
    end else if (st) begin
    end else if (w[15:8] == 8'h9A) begin
      off = int'(w[7:0]);
      if (off > 127) off -= 256;
      tgt = (m_pc + 1 + off + 256) % 256;
      m_valid = 0;
      if (tgt == m_pc) m_halted = 1;
      m_pc = tgt;
    end else begin
      m_ir = w; m_ir_pc = m_pc; m_valid = 1; m_pc = (m_pc + 1) % 256;
    end
  endtask

  task automatic cycle(input bit rst, input bit run, input bit st, input bit rd,
                       input logic [7:0] ra);
    @(negedge i_clk);
    i_rst = rst; i_run_en = run; i_stall = st; i_redirect_en = rd; i_redirect_addr = ra;
    model_step(rst, run, st, rd, int'(ra));
    @(posedge i_clk);
    #1;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, ".pc"}, 32'(o_pc_out), 32'(m_pc));
    chk({tag, ".ir"}, 32'(o_ir_out), 32'(m_ir));
    chk({tag, ".ir_pc"}, 32'(o_ir_pc), 32'(m_ir_pc));
    chk({tag, ".valid"}, 32'(o_ir_valid), 32'(m_valid));
    chk({tag, ".halted"}, 32'(o_halted), 32'(m_halted));
  endtask

  task automatic mcycle(input string tag, input bit rst, input bit run, input bit st,
                        input bit rd, input logic [7:0] ra);
    cycle(rst, run, st, rd, ra);
    cmp_model(tag);
  endtask

  initial begin
    logic [15:0] w;
    bit r_rst, r_run, r_st, r_rd;

    // Table-driven: basic fetch, stall, redirect under stall, halt, JUMPR back to 0.
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h1111; rom[8'h01] = 16'h2222; rom[8'h02] = 16'h3333;
    rom[8'h03] = 16'h4444; rom[8'h40] = 16'h4040; rom[8'h41] = 16'h9AFF;
    rom[8'h18] = 16'h9AE7;
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'h0000, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 16'h1111, 8'h00, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h02, 16'h2222, 8'h01, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h03, 16'h3333, 8'h02, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h03, 16'h3333, 8'h02, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 8'h40, 8'h40, 16'h3333, 8'h02, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h41, 16'h4040, 8'h40, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h41, 16'h4040, 8'h40, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h41, 16'h4040, 8'h40, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'h18, 8'h18, 16'h4040, 8'h40, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'h4040, 8'h40, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 16'h1111, 8'h00, 1'b1, 1'b0};
    for (int i = 0; i < 13; i++) begin
      cycle(vecs[i].rst, vecs[i].run, vecs[i].stall, vecs[i].redir, vecs[i].raddr);
      chk($sformatf("vec%0d.pc", i), 32'(o_pc_out), 32'(vecs[i].pc));
      chk($sformatf("vec%0d.ir", i), 32'(o_ir_out), 32'(vecs[i].ir));
      chk($sformatf("vec%0d.ir_pc", i), 32'(o_ir_pc), 32'(vecs[i].irpc));
      chk($sformatf("vec%0d.valid", i), 32'(o_ir_valid), 32'(vecs[i].v));
      chk($sformatf("vec%0d.halted", i), 32'(o_halted), 32'(vecs[i].h));
    end

    // Stall for three cycles at pc 5, then release.
    for (int i = 0; i < 256; i++) rom[i] = 16'h1000 + 16'(i);
    mcycle("st.rst", 1, 0, 0, 0, 8'h00);
    mcycle("st.run", 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) mcycle("st.fetch", 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      mcycle("st.hold", 0, 0, 1, 0, 8'h00);
      chk("stall.pc", 32'(o_pc_out), 32'h05);
      chk("stall.ir", 32'(o_ir_out), 32'h1004);
      chk("stall.valid", 32'(o_ir_valid), 32'h1);
    end
    mcycle("st.rel", 0, 0, 0, 0, 8'h00);
    chk("release.ir", 32'(o_ir_out), 32'h1005);
    chk("release.pc", 32'(o_pc_out), 32'h06);

    // Jump-to-self parks for ten cycles regardless of stall/run_en; redirect resumes.
    rom[8'h30] = 16'h9AFF;
    mcycle("h.redir", 0, 0, 0, 1, 8'h30);
    mcycle("h.enter", 0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      mcycle("h.park", 0, 1'($urandom), 1'($urandom), 0, 8'h00);
      chk("halt.pc", 32'(o_pc_out), 32'h30);
      chk("halt.flag", 32'(o_halted), 32'h1);
    end
    mcycle("h.exit", 0, 0, 0, 1, 8'h00);
    chk("halt.exit_flag", 32'(o_halted), 32'h0);
    chk("halt.exit_pc", 32'(o_pc_out), 32'h00);
    mcycle("h.resume", 0, 0, 0, 0, 8'h00);
    chk("halt.resume_ir", 32'(o_ir_out), 32'h1000);

    // Wrap on increment and on jump target.
    rom[8'hFF] = 16'h0000;
    mcycle("w.redir", 0, 0, 0, 1, 8'hFF);
    mcycle("w.inc", 0, 0, 0, 0, 8'h00);
    chk("wrap.pc", 32'(o_pc_out), 32'h00);
    chk("wrap.ir_pc", 32'(o_ir_pc), 32'hFF);
    rom[8'hF0] = 16'h9A20;
    mcycle("w.redir2", 0, 0, 0, 1, 8'hF0);
    mcycle("w.jump", 0, 0, 0, 0, 8'h00);
    chk("wrapjump.pc", 32'(o_pc_out), 32'h11);
    chk("wrapjump.valid", 32'(o_ir_valid), 32'h0);

    // Reset while halted and stalled.
    mcycle("r.redir", 0, 0, 0, 1, 8'h30);
    mcycle("r.halt", 0, 0, 0, 0, 8'h00);
    mcycle("r.rst", 1, 1, 1, 1, 8'h55);
    chk("rst.pc", 32'(o_pc_out), 32'h00);
    chk("rst.ir", 32'(o_ir_out), 32'h0000);
    chk("rst.halted", 32'(o_halted), 32'h0);
    chk("rst.valid", 32'(o_ir_valid), 32'h0);

    // Redirect in IDLE loads PC without starting; run_en drop in RUN is ignored.
    mcycle("i.redir", 0, 0, 0, 1, 8'h22);
    mcycle("i.wait", 0, 0, 0, 0, 8'h00);
    chk("idle.pc", 32'(o_pc_out), 32'h22);
    chk("idle.valid", 32'(o_ir_valid), 32'h0);
    mcycle("i.run", 0, 1, 0, 0, 8'h00);
    mcycle("i.fetch", 0, 0, 0, 0, 8'h00);
    chk("idle.first_pc", 32'(o_pc_out), 32'h23);
    chk("idle.first_ir", 32'(o_ir_out), 32'h1022);
    for (int i = 0; i < 3; i++) mcycle("i.norun", 0, 0, 0, 0, 8'h00);

    // Random ROM and control against the reference model.
    for (int i = 0; i < 256; i++) begin
      w = 16'($urandom);
      if ($urandom_range(0, 5) == 0) w[15:8] = 8'h9A;
      else if (w[15:8] == 8'h9A) w[15:8] = 8'h9B;
      rom[i] = w;
    end
    mcycle("rnd.rst", 1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3000; i++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_run = 1'($urandom);
      r_st  = ($urandom_range(0, 3) == 0);
      r_rd  = ($urandom_range(0, 15) == 0);
      mcycle("rnd", r_rst, r_run, r_st, r_rd, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
